// File: rtl/rggen_backdoor_responder.sv
// Backdoor request/response endpoint for one register field: queues requests and applies
// them as a single-cycle masked strobe or value sample. Optional macro: RGGEN_BACKDOOR_FRONTDOOR_STALL_EN.
module rggen_backdoor_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_bd_valid,
    output logic                  o_bd_ready,
    input  logic                  i_bd_write,
    input  logic [DATA_WIDTH-1:0] i_bd_mask,
    input  logic [DATA_WIDTH-1:0] i_bd_data,
    output logic                  o_bd_resp_valid,
    input  logic                  i_bd_resp_ready,
    output logic [DATA_WIDTH-1:0] o_bd_resp_data,
    input  logic [DATA_WIDTH-1:0] i_field_value,
    input  logic                  i_frontdoor_valid,
    output logic                  o_bd_write_valid,
    output logic [DATA_WIDTH-1:0] o_bd_write_mask,
    output logic [DATA_WIDTH-1:0] o_bd_write_data,
    output logic                  o_busy
);
    localparam int PTR_W       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int MEM_ENTRIES = 1 << PTR_W;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t                  state_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [2:0]              count_reg;
    logic [2:0]              count_next;
    logic                    ready_reg;
    logic                    busy_reg;
    logic                    resp_valid_reg;
    logic [DATA_WIDTH-1:0]   resp_data_reg;

    logic                    mem_write [MEM_ENTRIES];
    logic [DATA_WIDTH-1:0]   mem_mask  [MEM_ENTRIES];
    logic [DATA_WIDTH-1:0]   mem_data  [MEM_ENTRIES];

    logic                    push;
    logic                    pop;
    logic                    stall;
    logic                    start_access;
    logic                    active_next;
    logic                    head_write;
    logic [DATA_WIDTH-1:0]   head_mask;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [DATA_WIDTH-1:0]   merged_value;

`ifdef RGGEN_BACKDOOR_FRONTDOOR_STALL_EN
    assign stall = i_frontdoor_valid;
`else
    // Field storage resolves same-cycle collisions in favour of the backdoor strobe.
    logic unused_frontdoor;
    assign unused_frontdoor = i_frontdoor_valid;
    assign stall            = 1'b0;
`endif

    // Ready is registered, so a pop in the same cycle never opens room for a push.
    assign push         = i_bd_valid && ready_reg;
    assign pop          = (state_reg == ACCESS);
    assign start_access = (state_reg == IDLE) && (count_reg != 3'd0) && !stall;
    assign count_next   = count_reg + {2'b00, push} - {2'b00, pop};
    assign active_next  = start_access || (state_reg == ACCESS) ||
                          ((state_reg == RESPOND) && !i_bd_resp_ready);

    generate
        for (genvar gi = 0; gi < MEM_ENTRIES; gi++) begin : g_entry
            always_ff @(posedge i_clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_write[gi] <= i_bd_write;
                    mem_mask[gi]  <= i_bd_mask;
                    mem_data[gi]  <= i_bd_data;
                end
            end
        end
    endgenerate

    assign head_write   = mem_write[rd_ptr_reg];
    assign head_mask    = mem_mask[rd_ptr_reg];
    assign head_data    = mem_data[rd_ptr_reg];
    assign merged_value = (i_field_value & ~head_mask) | (head_data & head_mask);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= 3'd0;
            ready_reg      <= 1'b1;
            busy_reg       <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_access) state_reg <= ACCESS;
                end
                ACCESS: begin
                    resp_data_reg  <= head_write ? merged_value : i_field_value;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= RESPOND;
                end
                RESPOND: begin
                    if (i_bd_resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            ready_reg <= (count_next < 3'(QUEUE_DEPTH));
            busy_reg  <= (count_next != 3'd0) || active_next;
        end
    end

    assign o_bd_ready       = ready_reg;
    assign o_busy           = busy_reg;
    assign o_bd_resp_valid  = resp_valid_reg;
    assign o_bd_resp_data   = resp_data_reg;
    assign o_bd_write_valid = (state_reg == ACCESS) && head_write;
    assign o_bd_write_mask  = o_bd_write_valid ? head_mask : '0;
    assign o_bd_write_data  = o_bd_write_valid ? head_data : '0;
endmodule

// File: doc/rggen_backdoor_responder.md
# rggen_backdoor_responder

RTL-side endpoint of the register backdoor channel: accepts read/write requests issued by the testbench through the backdoor interface, queues them, applies them to one register field's storage with a single-cycle masked write strobe or a value sample, and returns one response per request. Sits beside each field's storage flop in backdoor-enabled builds; the testbench-side registry and handle lookup drive its request and response channels.

## Interface
- DATA_WIDTH, 32: field storage width in bits.
- QUEUE_DEPTH, 2: request queue entries; legal range 1-4.
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_bd_valid  input  1  request valid.
- o_bd_ready  output  1  request ready; high when the queue is not full.
- i_bd_write  input  1  1 = write, 0 = read.
- i_bd_mask  input  DATA_WIDTH  per-bit write enable (ignored for reads).
- i_bd_data  input  DATA_WIDTH  write data.
- o_bd_resp_valid  output  1  response valid.
- i_bd_resp_ready  input  1  response ready.
- o_bd_resp_data  output  DATA_WIDTH  read value, or post-write value for writes.
- i_field_value  input  DATA_WIDTH  current field storage value.
- i_frontdoor_valid  input  1  frontdoor bus access to this field in progress.
- o_bd_write_valid  output  1  one-cycle write strobe to field storage.
- o_bd_write_mask  output  DATA_WIDTH  write mask to field storage.
- o_bd_write_data  output  DATA_WIDTH  write data to field storage.
- o_busy  output  1  queue non-empty or FSM not IDLE.

## Operation
- Request accepted on a rising edge where i_bd_valid && o_bd_ready; entry {write, mask, data} pushed into the FIFO. Requests complete in acceptance order.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE -> ACCESS when the queue is non-empty and the stall condition (see Configuration) is false; otherwise stay in IDLE.
- ACCESS (exactly one cycle):
  - Write head: o_bd_write_valid=1, mask/data driven from the head entry; response register <= (i_field_value & ~mask) | (data & mask).
  - Read head: no strobe; response register <= i_field_value.
  - Head popped on exit; -> RESPOND.
- RESPOND: o_bd_resp_valid=1, o_bd_resp_data stable; on i_bd_resp_ready -> IDLE.
- Push and pop in the same cycle with the queue full: push accepted only if o_bd_ready was already high (ready never depends on the same-cycle pop).
- o_bd_write_mask/data are zero whenever o_bd_write_valid=0.
- A write with an all-zero mask still strobes and returns i_field_value.
- Reset (any time, including mid-ACCESS or RESPOND): queue emptied, FSM -> IDLE, pending response dropped.

## Timing
- Reset values: o_bd_ready=1, o_bd_resp_valid=0, o_bd_resp_data=0, o_bd_write_valid=0, o_bd_write_mask=0, o_bd_write_data=0, o_busy=0.
- Uncontended latency, with acceptance at edge N: ACCESS during cycle N+1..N+2, so o_bd_write_valid is high for that cycle; o_bd_resp_valid rises at edge N+2.
- Back-to-back throughput: one request per 3 cycles with i_bd_resp_ready tied high (IDLE, ACCESS, RESPOND).
- All outputs are registered except o_bd_write_valid, mask and data, which decode directly from the FSM state and the queue head.

## Configuration
- RGGEN_BACKDOOR_FRONTDOOR_STALL_EN defined: the IDLE -> ACCESS transition is blocked while i_frontdoor_valid=1, so backdoor accesses never coincide with frontdoor accesses.
- Not defined: i_frontdoor_valid is ignored. On a same-cycle collision the field storage must give the backdoor strobe priority.

## Test plan
- Read, idle queue: i_field_value=0x1234_5678, read accepted at N -> o_bd_resp_valid at N+2 with data 0x1234_5678; no write strobe.
- Masked write: field=0xFFFF_0000, mask=0x0000_FFFF, data=0x0000_ABCD -> strobe at N+1 with that mask/data; response 0xFFFF_ABCD.
- Queue full: QUEUE_DEPTH=2 and i_bd_resp_ready=0, issue 4 requests -> o_bd_ready low after the queue holds 2 with 1 in RESPOND; responses return in order once ready rises.
- Stall (macro defined): i_frontdoor_valid high for 5 cycles around a write -> strobe only after i_frontdoor_valid falls. Without the macro, the strobe occurs at N+1.
- Response backpressure: i_bd_resp_ready low for 4 cycles -> o_bd_resp_valid and data held stable; IDLE is entered the cycle after ready rises.
- Reset mid-RESPOND with 1 queued entry: all outputs return to reset values, o_busy=0, and no strobe occurs after reset deasserts.
